fir_out_stage: RTL
==================

# fir_out_stage

Output conditioning stage placed directly downstream of the 4-tap `fir` datapath; it consumes the 36-bit accumulator output `y_out` of the filter. Each accepted sample is rounded, right-shifted and saturated to a narrow signed word, then buffered in a small FIFO behind a valid/ready interface so that a stalling consumer does not block the free-running filter. Pipeline warm-up samples are discarded, and samples lost to a full FIFO are counted.

## Interface
- `IN_W`, 36: width of the signed filter output.
- `OUT_W`, 16: width of the signed conditioned output.
- `SHIFT`, 15: number of fractional LSBs removed, ≥1.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `WARMUP`, 3: number of initial valid samples discarded after reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `y_in` carries a filter sample this cycle.
- `y_in` in IN_W: signed two's-complement filter output.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head this cycle.
- `y_out` out OUT_W: signed conditioned sample at the FIFO head.
- `sat_out` out 1: the head sample was saturated.
- `drop_cnt` out 16: samples lost to a full FIFO; saturates at 0xFFFF.

## Operation
- Warm-up: a counter counts accepted `in_valid` samples up to WARMUP. While the count is below WARMUP, samples are discarded silently and not counted in `drop_cnt`. Reset restarts warm-up.
- Stage 1 (register), on a valid post-warm-up sample:
  - `r = (y_in + 2^(SHIFT-1)) >>> SHIFT`, computed at IN_W+1 bits so the rounding add cannot overflow. This is round half toward +inf.
  - If `r > 2^(OUT_W-1)-1`, clamp to the max and set sat=1. If `r < -2^(OUT_W-1)`, clamp to the min and set sat=1. Otherwise sat=0.
  - Stage-1 valid is registered alongside the data.
- FIFO: DEPTH entries of {sat, data}. It is first-word-fall-through: `y_out`/`sat_out` always show the head.
- Push occurs when stage-1 is valid and the FIFO is not full after accounting for a same-cycle pop.
- If stage-1 is valid and the FIFO is full with no pop, the sample is dropped and `drop_cnt` increments, holding at 0xFFFF.
- Pop occurs when `out_valid && out_ready`. `out_ready` while empty has no effect.
- Simultaneous push and pop:
  - When full: both occur, the occupancy stays DEPTH, and nothing is dropped.
  - When empty: the push occurs, the pop does not, and `out_valid` rises next cycle.
- Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full/empty are decoded from the MSB and the remaining bits.
- `drop_cnt` is cleared only by reset.

## Timing
- Reset (async assert, sync-safe deassert by the system) has the following effects:
  - `out_valid`=0, `y_out`=0, `sat_out`=0, `drop_cnt`=0.
  - FIFO emptied, stage-1 valid cleared, warm-up counter cleared.
- Reset asserted mid-operation discards all buffered samples immediately.
- Latency: a sample with `in_valid` sampled at edge N is in the stage-1 register after edge N, is written to the FIFO at edge N+1, and appears with `out_valid`=1 after edge N+1. That is 2 cycles into an empty FIFO.
- Throughput: 1 sample/cycle sustained while `out_ready`=1.
- `y_out`/`sat_out` are stable while `out_valid`=1 and `out_ready`=0.
- Registered outputs: all outputs come from flops or the FIFO storage mux, with no combinational path from `out_ready` to `out_valid`.

## Test plan
All scenarios use default parameters.
- Warm-up: after reset release, 5 consecutive `in_valid` samples with values 1..5 × 2^15. The first 3 are discarded; `y_out` then presents 4, then 5. `drop_cnt`=0.
- Rounding: post-warm-up samples 114688, then −16384, then −16385, with `out_ready`=1. Outputs are 4, 0, −1, all with `sat_out`=0. Each appears 2 cycles after its input.
- Saturation: inputs 2^31, −2^31 and 32767·2^15. Outputs are 32767 (sat=1), −32768 (sat=1) and 32767 (sat=0).
- Backpressure and drop: hold `out_ready`=0 and stream 10 valid post-warm-up samples. Exactly 4 are held and `drop_cnt`=6. Then raise `out_ready`: the 4 held samples drain in order, after which `out_valid`=0.
- Full-with-pop: FIFO full, `out_ready`=1 and stage-1 valid continuously. Occupancy stays 4, `drop_cnt` is unchanged, and output order matches input order.
- Async reset mid-stream: assert `reset`=0 between clock edges with 3 samples buffered. `out_valid` goes to 0 and `drop_cnt` to 0 without waiting for a clock edge, and the warm-up discard repeats after release.

Source files
------------

// File: rtl/fir_out_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_out_stage                                                   |
// | Brief    : Round/shift/saturate FIR output into a FWFT FIFO with drop count |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fir_out_stage #(
    parameter int IN_W   = 36,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    parameter int DEPTH  = 4,
    parameter int WARMUP = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y_out,
    output logic                    sat_out,
    output logic [15:0]             drop_cnt
);

    localparam int c_AW  = $clog2(DEPTH);
    localparam int c_PW  = c_AW + 1;
    localparam int c_WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [c_WCW-1:0]       c_WARMUP = c_WCW'(WARMUP);
    localparam logic signed [IN_W:0]   c_ONE    = (IN_W + 1)'(1);
    localparam logic signed [IN_W:0]   c_ROUND  = c_ONE <<< (SHIFT - 1);
    localparam logic signed [IN_W:0]   c_MAX    = (c_ONE <<< (OUT_W - 1)) - c_ONE;
    localparam logic signed [IN_W:0]   c_MIN    = -(c_ONE <<< (OUT_W - 1));

    logic [c_WCW-1:0]        r_warm_cnt;
    logic                    w_warm_done;

    logic signed [IN_W:0]    w_ext;
    logic signed [IN_W:0]    w_sum;
    logic signed [IN_W:0]    w_rnd;
    logic [OUT_W-1:0]        w_s1_data;
    logic                    w_s1_sat;

    logic                    r_s1_valid;
    logic [OUT_W-1:0]        r_s1_data;
    logic                    r_s1_sat;

    logic [c_PW-1:0]         r_wp;
    logic [c_PW-1:0]         r_rp;
    logic [OUT_W:0]          r_mem [DEPTH];
    logic [OUT_W:0]          w_head;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [15:0]             r_drop_cnt;

    assign w_warm_done = (r_warm_cnt == c_WARMUP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_warm_cnt <= '0;
        end else if (in_valid && !w_warm_done) begin
            r_warm_cnt <= r_warm_cnt + c_WCW'(1);
        end
    end

    // One extra bit of headroom so the rounding offset can never wrap.
    assign w_ext = {y_in[IN_W-1], y_in};
    assign w_sum = w_ext + c_ROUND;
    assign w_rnd = w_sum >>> SHIFT;

    always_comb begin
        w_s1_data = w_rnd[OUT_W-1:0];
        w_s1_sat  = 1'b0;
        if (w_rnd > c_MAX) begin
            w_s1_data = c_MAX[OUT_W-1:0];
            w_s1_sat  = 1'b1;
        end else if (w_rnd < c_MIN) begin
            w_s1_data = c_MIN[OUT_W-1:0];
            w_s1_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_sat   <= 1'b0;
        end else begin
            r_s1_valid <= in_valid && w_warm_done;
            if (in_valid && w_warm_done) begin
                r_s1_data <= w_s1_data;
                r_s1_sat  <= w_s1_sat;
            end
        end
    end

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[c_AW] != r_rp[c_AW]) && (r_wp[c_AW-1:0] == r_rp[c_AW-1:0]);
    assign w_pop   = !w_empty && out_ready;
    // A pop frees the slot this cycle, so a full FIFO still accepts the push.
    assign w_push  = r_s1_valid && (!w_full || w_pop);
    assign w_drop  = r_s1_valid && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wp[c_AW-1:0]] <= {r_s1_sat, r_s1_data};
                r_wp                  <= r_wp + c_PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + c_PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign w_head    = r_mem[r_rp[c_AW-1:0]];
    assign out_valid = !w_empty;
    assign y_out     = w_head[OUT_W-1:0];
    assign sat_out   = w_head[OUT_W];
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
